// File: rtl/sseg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with double-buffered display data.
// Optional PWM dimming per digit slot: define SSEG_SCAN_DIM_EN to add the bright port.
module sseg_scan_ctrl #(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned PRESCALE = 1000,
    parameter int unsigned BLANK    = 16,
    parameter int unsigned INV      = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  lzs,
`ifdef SSEG_SCAN_DIM_EN
    input  logic [3:0]            bright,
`endif
    output logic                  pending,
    output logic                  frame,
    output logic [DIGITS-1:0]     digit_en,
    output logic [6:0]            sseg,
    output logic                  dp
);

    localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned IW = $clog2(DIGITS);
    localparam logic [CW-1:0] CNT_MAX = CW'(PRESCALE - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(DIGITS - 1);
    localparam logic          POL     = (INV != 0);

    logic [CW-1:0]       cnt_q, cnt_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [4*DIGITS-1:0] sh_data_q, sh_data_d, dsp_data_q, dsp_data_d;
    logic [DIGITS-1:0]   sh_dp_q, sh_dp_d, dsp_dp_q, dsp_dp_d;
    logic                pending_q, pending_d;
    logic                frame_q;
    logic [DIGITS-1:0]   digit_en_q, en_d;
    logic [6:0]          sseg_q, seg_d;
    logic                dp_q, dp_d;

    logic                last_cnt, boundary, zero_run, supp_sel, dp_sel, dim_ok, lit;
    logic [DIGITS-1:0]   supp;
    logic [3:0]          nib;
    logic [31:0]         cnt_u;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
        endcase
    endfunction

    always_comb begin
        last_cnt = (cnt_q == CNT_MAX);
        boundary = last_cnt && (idx_q == IDX_MAX);
        cnt_d    = last_cnt ? '0 : cnt_q + 1'b1;
        idx_d    = idx_q;
        if (last_cnt)
            idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;

        sh_data_d  = sh_data_q;
        sh_dp_d    = sh_dp_q;
        dsp_data_d = dsp_data_q;
        dsp_dp_d   = dsp_dp_q;
        pending_d  = pending_q;
        if (load) begin
            sh_data_d = data;
            sh_dp_d   = dp_in;
        end
        // A load landing on the boundary bypasses the shadow so it is not delayed a frame.
        if (boundary && load) begin
            dsp_data_d = data;
            dsp_dp_d   = dp_in;
            pending_d  = 1'b0;
        end else if (boundary && pending_q) begin
            dsp_data_d = sh_data_q;
            dsp_dp_d   = sh_dp_q;
            pending_d  = 1'b0;
        end else if (load) begin
            pending_d  = 1'b1;
        end

        zero_run = 1'b1;
        supp     = '0;
        for (int unsigned k = 1; k < DIGITS; k++) begin
            zero_run = zero_run & (dsp_data_q[(DIGITS-k)*4 +: 4] == 4'h0);
            supp[DIGITS-k] = lzs & zero_run;
        end

        nib      = '0;
        dp_sel   = 1'b0;
        supp_sel = 1'b0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                nib      = dsp_data_q[i*4 +: 4];
                dp_sel   = dsp_dp_q[i];
                supp_sel = supp[i];
            end
        end

        cnt_u = 32'(cnt_q);
`ifdef SSEG_SCAN_DIM_EN
        dim_ok = ((cnt_u - BLANK) << 4) < ((32'(bright) + 32'd1) * (PRESCALE - BLANK));
`else
        dim_ok = 1'b1;
`endif
        lit   = (cnt_u >= BLANK) && !supp_sel && dim_ok;
        en_d  = lit ? (DIGITS'(1) << idx_q) : '0;
        seg_d = lit ? hex7(nib) : '0;
        dp_d  = lit & dp_sel;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            idx_q      <= '0;
            sh_data_q  <= '0;
            sh_dp_q    <= '0;
            dsp_data_q <= '0;
            dsp_dp_q   <= '0;
            pending_q  <= 1'b0;
            frame_q    <= 1'b0;
            digit_en_q <= {DIGITS{POL}};
            sseg_q     <= {7{POL}};
            dp_q       <= POL;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            sh_data_q  <= sh_data_d;
            sh_dp_q    <= sh_dp_d;
            dsp_data_q <= dsp_data_d;
            dsp_dp_q   <= dsp_dp_d;
            pending_q  <= pending_d;
            frame_q    <= boundary;
            digit_en_q <= POL ? ~en_d : en_d;
            sseg_q     <= POL ? ~seg_d : seg_d;
            dp_q       <= POL ? ~dp_d : dp_d;
        end
    end

    assign pending  = pending_q;
    assign frame    = frame_q;
    assign digit_en = digit_en_q;
    assign sseg     = sseg_q;
    assign dp       = dp_q;

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Directed bench for sseg_scan_ctrl (DIGITS=4, PRESCALE=8, BLANK=2, INV=1).
// Cycle c after reset release shows the registered result of scan state c-1.
module tb_sseg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [15:0] data;
    logic [3:0]  dp_in;
    logic        lzs;
    logic        pending, frame, dp;
    logic [3:0]  digit_en;
    logic [6:0]  sseg;

    always #5 clk = ~clk;

`ifdef SSEG_SCAN_DIM_EN
    logic [3:0]  bright_full = 4'hF;
    logic [3:0]  bright_dim;
    logic        dim_pending, dim_frame, dim_dp;
    logic [3:0]  dim_en;
    logic [6:0]  dim_sseg;
`endif

    sseg_scan_ctrl #(.DIGITS(4), .PRESCALE(8), .BLANK(2), .INV(1)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .data     (data),
        .dp_in    (dp_in),
        .lzs      (lzs),
`ifdef SSEG_SCAN_DIM_EN
        .bright   (bright_full),
`endif
        .pending  (pending),
        .frame    (frame),
        .digit_en (digit_en),
        .sseg     (sseg),
        .dp       (dp)
    );

`ifdef SSEG_SCAN_DIM_EN
    sseg_scan_ctrl #(.DIGITS(4), .PRESCALE(34), .BLANK(2), .INV(1)) u_dim (
        .clk      (clk),
        .rst      (rst),
        .load     (1'b0),
        .data     (16'h0000),
        .dp_in    (4'h0),
        .lzs      (1'b0),
        .bright   (bright_dim),
        .pending  (dim_pending),
        .frame    (dim_frame),
        .digit_en (dim_en),
        .sseg     (dim_sseg),
        .dp       (dim_dp)
    );
`endif

    typedef struct {
        int unsigned cyc;
        logic        ld;
        logic [15:0] d;
        logic [3:0]  dpi;
        logic        lz;
        logic [3:0]  en;
        logic [6:0]  sg;
        logic        dpo;
        logic        pend;
        logic        frm;
        string       nm;
    } vec_t;

    vec_t        tv[$];
    int unsigned cyc;
    int unsigned n_chk, n_fail;

    function automatic vec_t mk(input int unsigned c, input logic l, input logic [15:0] d,
                                input logic [3:0] dpi, input logic lz, input logic [3:0] en,
                                input logic [6:0] sg, input logic dpo, input logic p,
                                input logic f, input string nm);
        vec_t v;
        v.cyc = c; v.ld = l; v.d = d; v.dpi = dpi; v.lz = lz;
        v.en = en; v.sg = sg; v.dpo = dpo; v.pend = p; v.frm = f; v.nm = nm;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        load = 1'b0;
    endtask

    task automatic cmp(input string nm, input string fld, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s at cycle %0d: got %0h, expected %0h", nm, fld, cyc, act, exp);
        end
    endtask

    task automatic chk(input string nm, input logic [3:0] en, input logic [6:0] sg,
                       input logic d, input logic p, input logic f);
        cmp(nm, "digit_en", 32'(digit_en), 32'(en));
        cmp(nm, "sseg",     32'(sseg),     32'(sg));
        cmp(nm, "dp",       32'(dp),       32'(d));
        cmp(nm, "pending",  32'(pending),  32'(p));
        cmp(nm, "frame",    32'(frame),    32'(f));
    endtask

    initial begin
        int unsigned lit_cnt;
        rst = 1'b1; load = 1'b0; data = '0; dp_in = '0; lzs = 1'b0;
`ifdef SSEG_SCAN_DIM_EN
        bright_dim = 4'h0;
`endif
        n_chk = 0; n_fail = 0; cyc = 0;

        //          cyc  ld  data      dpi   lz  en    sseg   dp pend frm
        tv.push_back(mk(  0, 0, 16'h0000, 4'h0, 0, 4'hF, 7'h7F, 1, 0, 0, "reset"));
        tv.push_back(mk(  1, 0, 16'h0000, 4'h0, 0, 4'hF, 7'h7F, 1, 0, 0, "blank0"));
        tv.push_back(mk(  3, 0, 16'h0000, 4'h0, 0, 4'hE, 7'h40, 1, 0, 0, "zero_d0"));
        tv.push_back(mk( 31, 0, 16'h0000, 4'h0, 0, 4'h7, 7'h40, 1, 0, 0, "pre_frame"));
        tv.push_back(mk( 32, 0, 16'h0000, 4'h0, 0, 4'h7, 7'h40, 1, 0, 1, "frame1"));
        tv.push_back(mk( 33, 0, 16'h0000, 4'h0, 0, 4'hF, 7'h7F, 1, 0, 0, "post_frame"));
        tv.push_back(mk( 40, 1, 16'h1234, 4'h0, 0, 4'hE, 7'h40, 1, 0, 0, "load1234"));
        tv.push_back(mk( 41, 0, 16'h0000, 4'h0, 0, 4'hF, 7'h7F, 1, 1, 0, "pend_set"));
        tv.push_back(mk( 63, 0, 16'h0000, 4'h0, 0, 4'h7, 7'h40, 1, 1, 0, "pend_hold"));
        tv.push_back(mk( 64, 0, 16'h0000, 4'h0, 0, 4'h7, 7'h40, 1, 0, 1, "pend_clr"));
        tv.push_back(mk( 67, 0, 16'h0000, 4'h0, 0, 4'hE, 7'h19, 1, 0, 0, "d0_4"));
        tv.push_back(mk( 75, 0, 16'h0000, 4'h0, 0, 4'hD, 7'h30, 1, 0, 0, "d1_3"));
        tv.push_back(mk( 91, 0, 16'h0000, 4'h0, 0, 4'h7, 7'h79, 1, 0, 0, "d3_1"));
        tv.push_back(mk(100, 1, 16'hAAAA, 4'h0, 0, 4'hE, 7'h19, 1, 0, 0, "loadAAAA"));
        tv.push_back(mk(101, 0, 16'h0000, 4'h0, 0, 4'hE, 7'h19, 1, 1, 0, "pend3"));
        tv.push_back(mk(110, 1, 16'h5555, 4'h1, 0, 4'hD, 7'h30, 1, 1, 0, "load5555"));
        tv.push_back(mk(127, 0, 16'h0000, 4'h0, 0, 4'h7, 7'h79, 1, 1, 0, "pend3_hold"));
        tv.push_back(mk(128, 0, 16'h0000, 4'h0, 0, 4'h7, 7'h79, 1, 0, 1, "pend3_clr"));
        tv.push_back(mk(131, 0, 16'h0000, 4'h0, 0, 4'hE, 7'h12, 0, 0, 0, "d0_5dp"));
        tv.push_back(mk(140, 1, 16'h0005, 4'h0, 1, 4'hD, 7'h12, 1, 0, 0, "d1_5"));
        tv.push_back(mk(147, 0, 16'h0000, 4'h0, 1, 4'hB, 7'h12, 1, 1, 0, "d2_5"));
        tv.push_back(mk(163, 0, 16'h0000, 4'h0, 1, 4'hE, 7'h12, 1, 0, 0, "lzs_d0"));
        tv.push_back(mk(170, 1, 16'h0000, 4'h0, 1, 4'hF, 7'h7F, 1, 0, 0, "lzs_blank"));
        tv.push_back(mk(171, 0, 16'h0000, 4'h0, 1, 4'hF, 7'h7F, 1, 1, 0, "lzs_d1"));
        tv.push_back(mk(174, 0, 16'h0000, 4'h0, 1, 4'hF, 7'h7F, 1, 1, 0, "lzs_d1b"));
        tv.push_back(mk(187, 0, 16'h0000, 4'h0, 1, 4'hF, 7'h7F, 1, 1, 0, "lzs_d3"));
        tv.push_back(mk(195, 0, 16'h0000, 4'h0, 1, 4'hE, 7'h40, 1, 0, 0, "lzs_zero_d0"));
        tv.push_back(mk(211, 0, 16'h0000, 4'h0, 1, 4'hF, 7'h7F, 1, 0, 0, "lzs_zero_d2"));
        tv.push_back(mk(212, 0, 16'h0000, 4'h0, 0, 4'hF, 7'h7F, 1, 0, 0, "lzs_off_pre"));
        tv.push_back(mk(213, 0, 16'h0000, 4'h0, 0, 4'hB, 7'h40, 1, 0, 0, "lzs_live"));
        tv.push_back(mk(230, 1, 16'h1111, 4'h0, 0, 4'hE, 7'h40, 1, 0, 0, "load1111"));
        tv.push_back(mk(243, 0, 16'h0000, 4'h0, 0, 4'hB, 7'h40, 1, 1, 0, "tear_free"));
        tv.push_back(mk(255, 1, 16'hBEEF, 4'h0, 0, 4'h7, 7'h40, 1, 1, 0, "bypass_pre"));
        tv.push_back(mk(256, 0, 16'h0000, 4'h0, 0, 4'h7, 7'h40, 1, 0, 1, "bypass_clr"));
        tv.push_back(mk(259, 0, 16'h0000, 4'h0, 0, 4'hE, 7'h0E, 1, 0, 0, "beef_d0"));
        tv.push_back(mk(267, 0, 16'h0000, 4'h0, 0, 4'hD, 7'h06, 1, 0, 0, "beef_d1"));
        tv.push_back(mk(283, 0, 16'h0000, 4'h0, 0, 4'h7, 7'h03, 1, 0, 0, "beef_d3"));
        tv.push_back(mk(291, 0, 16'h0000, 4'h0, 0, 4'hE, 7'h0E, 1, 0, 0, "beef_keep"));

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        cyc = 0;

        foreach (tv[j]) begin
            while (cyc < tv[j].cyc) step();
            chk(tv[j].nm, tv[j].en, tv[j].sg, tv[j].dpo, tv[j].pend, tv[j].frm);
            load = tv[j].ld;
            if (tv[j].ld) begin
                data  = tv[j].d;
                dp_in = tv[j].dpi;
            end
            lzs = tv[j].lz;
        end

        // Reset mid-scan with data pending: everything returns to reset values at once.
        while (cyc < 300) step();
        load = 1'b1; data = 16'h1234; dp_in = 4'h0;
        repeat (3) step();
        cmp("pend_before_rst", "pending", 32'(pending), 32'd1);
        rst = 1'b1;
        #1;
        chk("async_rst", 4'hF, 7'h7F, 1'b1, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        cyc = 0;
`ifdef SSEG_SCAN_DIM_EN
        step();
        cmp("dim_c1", "digit_en", 32'(dim_en), 32'hF);
`endif
        while (cyc < 3) step();
        chk("rst_dsp_lost", 4'hE, 7'h40, 1'b1, 1'b0, 1'b0);
`ifdef SSEG_SCAN_DIM_EN
        cmp("dim_c3", "digit_en", 32'(dim_en), 32'hE);
        step();
        cmp("dim_c4", "digit_en", 32'(dim_en), 32'hE);
        step();
        cmp("dim_c5", "digit_en", 32'(dim_en), 32'hF);
`endif
        while (cyc < 32) step();
        chk("rst_frame", 4'h7, 7'h40, 1'b1, 1'b0, 1'b1);
        while (cyc < 35) step();
        chk("rst_no_pend", 4'hE, 7'h40, 1'b1, 1'b0, 1'b0);
`ifdef SSEG_SCAN_DIM_EN
        bright_dim = 4'hF;
        while (cyc < 39) step();
        lit_cnt = 0;
        repeat (34) begin
            step();
            if (dim_en != 4'hF) lit_cnt++;
        end
        cmp("dim_full", "lit_cycles", 32'(lit_cnt), 32'd32);
`else
        lit_cnt = 0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sseg_scan_ctrl.md
Name: sseg_scan_ctrl

Overview:
Time-multiplexed scan controller for a bank of common-anode/cathode seven-segment digits that share one segment bus. It holds a double-buffered hex value and cycles one digit-enable at a time. For each digit it feeds that digit's nibble through an internal combinational sseg_decode (REG=0, INV=0) and inserts an anti-ghosting blank at the start of each digit slot. It supports leading-zero suppression, per-digit decimal points and tear-free updates at frame boundaries.

Parameters:
DIGITS, 4, number of digits scanned (2..8)
PRESCALE, 1000, clk cycles per digit slot (>= BLANK+2)
BLANK, 16, cycles at start of each slot with all digits and segments dark (>= 1)
INV, 1, 1 = digit_en/sseg/dp outputs active-low; 0 = active-high

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
load  in  1  one-cycle strobe; capture data/dp_in into shadow buffer
data  in  4*DIGITS  hex value; nibble i displayed on digit i (digit 0 = LSD)
dp_in  in  DIGITS  decimal point per digit
lzs  in  1  leading-zero suppression enable (level, sampled live)
pending  out  1  shadow buffer holds data not yet displayed
frame  out  1  one-cycle pulse at start of digit-0 slot
digit_en  out  DIGITS  one-hot digit enable (polarity per INV)
sseg  out  7  segments, bit0=a .. bit6=g (polarity per INV)
dp  out  1  decimal point (polarity per INV)

Behaviour:
- State: slot counter cnt (0..PRESCALE-1), digit index idx (0..DIGITS-1), shadow regs sh_data/sh_dp, display regs dsp_data/dsp_dp, pending flag.
- cnt increments every clk. At cnt==PRESCALE-1: cnt->0 and idx->idx+1; idx wraps DIGITS-1 -> 0.
- Boundary cycle = cnt==PRESCALE-1 and idx==DIGITS-1. On it: if pending, dsp <= sh and pending <= 0.
- load: sh <= data/dp_in and pending <= 1. A load while pending overwrites sh; last load wins.
- load on the boundary cycle: dsp <= data/dp_in directly (bypass), pending <= 0. The older shadow value is discarded.
- All outputs are registered and reflect the (cnt, idx, dsp) state of the previous cycle, giving one cycle of latency.
- frame is high in the cycle after the boundary cycle, i.e. coincident with the outputs for cnt=0, idx=0.
- Blank window (cnt < BLANK): all digit_en, sseg and dp inactive.
- Active window (cnt >= BLANK): digit_en bit idx active, others inactive; sseg = decode(dsp_data nibble idx); dp = dsp_dp[idx].
- Leading-zero suppression (lzs=1): digit i>0 is suppressed if nibbles i..DIGITS-1 are all zero. A suppressed digit keeps digit_en, sseg and dp inactive for its whole slot. Digit 0 is never suppressed. A set dp does not un-suppress a digit.
- Reset values: cnt=0, idx=0, dsp=0, sh=0, pending=0, frame=0. digit_en/sseg/dp inactive: all ones if INV=1, zeros if INV=0.
- Reset mid-scan: immediate return to the above values; any pending data is lost.

Optional Feature:
SSEG_SCAN_DIM_EN
- Defined: adds input port bright[3:0]. In the active window, the digit is lit only while (cnt-BLANK)*16 < (bright+1)*(PRESCALE-BLANK). Otherwise outputs are dark as in the blank window. bright=15 gives full on; bright is sampled live.
- Not defined: no bright port; the digit is lit for the entire active window.

Test Plan:
(DIGITS=4, PRESCALE=8, BLANK=2, INV=1 unless noted)
1. Reset release: digit_en=4'hF, sseg=7'h7F, dp=1, pending=0; first frame pulse 32 cycles after reset deasserts (boundary at cycle 31, frame at 32).
2. load data=16'h1234, dp_in=0 mid-frame -> pending=1 until boundary; next frame digit0 slot cnt>=2: digit_en=4'b1110, sseg=7'b0011001 ('4'); digit3 slot sseg=7'b1111001 ('1').
3. Two loads (16'hAAAA then 16'h5555) in the same frame -> only 5555 displayed; pending falls exactly at boundary.
4. lzs=1, data=16'h0005 -> digits 1..3 dark for whole slot, digit0 shows 7'b0010010; data=16'h0000 -> only digit0 lit, showing '0' (7'b1000000).
5. load 16'hBEEF asserted exactly on boundary cycle with a stale pending 16'h1111 -> BEEF shown in the next frame, pending=0; 1111 never displayed.
6. SSEG_SCAN_DIM_EN, PRESCALE=34, BLANK=2, bright=0 -> each digit lit only for cnt 2..3 (2 cycles); bright=15 -> lit for cnt 2..33.
